// File: rtl/latch_bank_pkg.sv
// Shared types for the latch_bank channel array and its snapshot port.
// Optional staleness tracking is enabled by defining LATCH_BANK_STALE_EN.
package latch_bank_pkg;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_FULL = 1'b1
    } snap_state_e;

endpackage

// File: rtl/latch_bank_chan.sv
// One storage channel: level/edge update strobe, data register, and optional
// staleness counter (compiled in when LATCH_BANK_STALE_EN is defined).
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STALE_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  mode_e            mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             stale
);

    if (WIDTH < 1 || STALE_LIMIT < 1) begin : g_param_err
        $error("latch_bank_chan: WIDTH and STALE_LIMIT must be at least 1");
    end

    logic en_prev;
    logic upd;

    assign upd    = (mode == MODE_EDGE) ? (enable & ~en_prev) : enable;
    assign q_next = upd ? d : q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            en_prev <= 1'b0;
        end else begin
            q       <= q_next;
            en_prev <= enable;
        end
    end

`ifdef LATCH_BANK_STALE_EN
    localparam int CW = $clog2(STALE_LIMIT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Saturates at the limit so stale stays asserted for an idle channel.
    always_comb begin
        cnt_next = cnt;
        if (upd) begin
            cnt_next = '0;
        end else if (cnt != CW'(STALE_LIMIT)) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            stale <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            stale <= (cnt_next == CW'(STALE_LIMIT));
        end
    end
`else
    assign stale = 1'b0;
`endif

endmodule

// File: rtl/latch_bank.sv
// CHANNELS-wide bank of level/edge update registers with an atomic snapshot
// port; per-channel staleness outputs exist only with LATCH_BANK_STALE_EN.
//
// state     | meaning
// SNAP_IDLE | no snapshot held, next snap_req captures the bank
// SNAP_FULL | snap_data holds an unread snapshot, snap_valid high
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int STALE_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    output logic [CHANNELS*WIDTH-1:0] q,
    input  logic                      snap_req,
    output logic [CHANNELS*WIDTH-1:0] snap_data,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic                      snap_drop,
    output logic [CHANNELS-1:0]       stale
);

    if (CHANNELS < 1) begin : g_param_err
        $error("latch_bank: CHANNELS must be at least 1");
    end

    logic [CHANNELS*WIDTH-1:0] q_next;
    snap_state_e               state;
    snap_state_e               state_next;
    logic                      snap_load;
    logic                      drop_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        latch_bank_chan #(
            .WIDTH       (WIDTH),
            .STALE_LIMIT (STALE_LIMIT)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .d      (d[i*WIDTH +: WIDTH]),
            .enable (enable[i]),
            .mode   (mode_e'(mode[i])),
            .q      (q[i*WIDTH +: WIDTH]),
            .q_next (q_next[i*WIDTH +: WIDTH]),
            .stale  (stale[i])
        );
    end

    // Snapshot captures q_next so same-cycle channel updates are included.
    always_comb begin
        state_next = state;
        snap_load  = 1'b0;
        drop_next  = 1'b0;
        case (state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    snap_load  = 1'b1;
                    state_next = SNAP_FULL;
                end
            end
            SNAP_FULL: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        snap_load = 1'b1;
                    end else begin
                        state_next = SNAP_IDLE;
                    end
                end else if (snap_req) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = SNAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SNAP_IDLE;
            snap_data <= '0;
            snap_drop <= 1'b0;
        end else begin
            state     <= state_next;
            snap_drop <= drop_next;
            if (snap_load) begin
                snap_data <= q_next;
            end
        end
    end

    assign snap_valid = (state == SNAP_FULL);

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: directed scenarios plus randomized
// traffic against a cycle-level reference model (LATCH_BANK_STALE_EN aware).
module tb_latch_bank;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int LIM = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*W-1:0]   d;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     mode;
    logic [CH*W-1:0]   q;
    logic              snap_req;
    logic [CH*W-1:0]   snap_data;
    logic              snap_valid;
    logic              snap_ready;
    logic              snap_drop;
    logic [CH-1:0]     stale;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [W-1:0]    m_q [CH];
    logic            m_prev [CH];
    int              m_age [CH];
    logic            m_full;
    logic [CH*W-1:0] m_snap;
    logic            m_drop;

    latch_bank #(.WIDTH(W), .CHANNELS(CH), .STALE_LIMIT(LIM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .enable     (enable),
        .mode       (mode),
        .q          (q),
        .snap_req   (snap_req),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_drop  (snap_drop),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_q[c]    = '0;
            m_prev[c] = 1'b0;
            m_age[c]  = 0;
        end
        m_full = 1'b0;
        m_snap = '0;
        m_drop = 1'b0;
    endtask

    function automatic logic [CH*W-1:0] model_qvec();
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = m_q[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] model_stale();
        logic [CH-1:0] s;
        s = '0;
`ifdef LATCH_BANK_STALE_EN
        for (int c = 0; c < CH; c++) s[c] = (m_age[c] >= LIM);
`endif
        return s;
    endfunction

    // One clock: predict from the inputs now applied, then advance to #1 after the edge.
    task automatic tick();
        logic [W-1:0]    nq [CH];
        logic [CH*W-1:0] nvec;
        logic            fire;
        logic            ndrop;
        for (int c = 0; c < CH; c++) begin
            fire = mode[c] ? (enable[c] && !m_prev[c]) : enable[c];
            nq[c] = fire ? d[c*W +: W] : m_q[c];
            nvec[c*W +: W] = nq[c];
            m_age[c] = fire ? 0 : m_age[c] + 1;
            m_prev[c] = enable[c];
        end
        ndrop = 1'b0;
        if (!m_full) begin
            if (snap_req) begin
                m_snap = nvec;
                m_full = 1'b1;
            end
        end else if (snap_ready) begin
            if (snap_req) m_snap = nvec;
            else          m_full = 1'b0;
        end else if (snap_req) begin
            ndrop = 1'b1;
        end
        m_drop = ndrop;
        for (int c = 0; c < CH; c++) m_q[c] = nq[c];
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
    endtask

    task automatic set_d(input int ch, input logic [W-1:0] v);
        d[ch*W +: W] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d = '0; enable = '0; mode = '0; snap_req = 1'b0; snap_ready = 1'b0;
        // edge-mode channel holding enable high across reset release
        mode[2] = 1'b1; enable[2] = 1'b1; set_d(2, 8'h5A);
        model_reset();
        tick();
        tick();
        n_cmp++; if (q !== '0) begin n_err++; $display("FAIL reset_q got=%h want=0", q); end
        n_cmp++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", snap_valid); end
        n_cmp++; if (snap_data !== '0) begin n_err++; $display("FAIL reset_data got=%h want=0", snap_data); end
        n_cmp++; if (snap_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop got=%b want=0", snap_drop); end
        n_cmp++; if (stale !== '0) begin n_err++; $display("FAIL reset_stale got=%b want=0", stale); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (q[2*W +: W] !== 8'h5A) begin n_err++; $display("FAIL edge_after_reset got=%h want=5a", q[2*W +: W]); end
        set_d(2, 8'h66);
        tick();
        n_cmp++; if (q[2*W +: W] !== 8'h5A) begin n_err++; $display("FAIL edge_held_high got=%h want=5a", q[2*W +: W]); end
        enable = '0; mode = '0;
        tick();
    endtask

    task automatic test_level();
        logic [W-1:0] exp_v [4];
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h33;
        mode[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enable[0] = (k < 3);
            set_d(0, 8'h11 * (k + 1));
            tick();
            n_cmp++;
            if (q[0 +: W] !== exp_v[k]) begin
                n_err++; $display("FAIL level_q0 step=%0d got=%h want=%h", k, q[0 +: W], exp_v[k]);
            end
        end
    endtask

    task automatic test_edge();
        mode[1] = 1'b1;
        enable[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_d(1, 8'hA0 + 8'(k));
            tick();
            n_cmp++;
            if (q[W +: W] !== 8'hA0) begin
                n_err++; $display("FAIL edge_q1 step=%0d got=%h want=a0", k, q[W +: W]);
            end
        end
        enable[1] = 1'b0;
        tick();
        enable[1] = 1'b1; set_d(1, 8'hB5);
        tick();
        n_cmp++; if (q[W +: W] !== 8'hB5) begin n_err++; $display("FAIL edge_recapture got=%h want=b5", q[W +: W]); end
        enable[1] = 1'b0; mode[1] = 1'b0;
        tick();
    endtask

    task automatic test_snapshot();
        mode = '0; enable = '1;
        d = {8'h04, 8'h03, 8'h02, 8'h01};
        tick();
        enable = 4'b0100; set_d(2, 8'h7F); snap_req = 1'b1;
        tick();
        n_cmp++; if (snap_valid !== 1'b1) begin n_err++; $display("FAIL snap_valid got=%b want=1", snap_valid); end
        n_cmp++;
        if (snap_data !== {8'h04, 8'h7F, 8'h02, 8'h01}) begin
            n_err++; $display("FAIL snap_data got=%h want=047f0201", snap_data);
        end
        enable = '0; snap_req = 1'b0; snap_ready = 1'b1;
        tick();
        n_cmp++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL snap_consumed got=%b want=0", snap_valid); end
        snap_ready = 1'b0;
    endtask

    task automatic test_overrun();
        snap_req = 1'b1;
        tick();
        enable = 4'b0001; set_d(0, 8'h55);
        tick();
        n_cmp++; if (snap_drop !== 1'b1) begin n_err++; $display("FAIL overrun_drop got=%b want=1", snap_drop); end
        n_cmp++;
        if (snap_data !== {8'h04, 8'h7F, 8'h02, 8'h01}) begin
            n_err++; $display("FAIL overrun_data got=%h want=047f0201", snap_data);
        end
        snap_req = 1'b0; enable = '0;
        tick();
        n_cmp++; if (snap_drop !== 1'b0) begin n_err++; $display("FAIL drop_one_cycle got=%b want=0", snap_drop); end
        snap_req = 1'b1; snap_ready = 1'b1; enable = 4'b0010; set_d(1, 8'h99);
        tick();
        n_cmp++; if (snap_drop !== 1'b0) begin n_err++; $display("FAIL b2b_no_drop got=%b want=0", snap_drop); end
        n_cmp++;
        if (snap_data !== {8'h04, 8'h7F, 8'h99, 8'h55} || snap_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_reload got=%h/%b want=047f9955/1", snap_data, snap_valid);
        end
        snap_req = 1'b0; enable = '0;
        tick();
        n_cmp++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL b2b_release got=%b want=0", snap_valid); end
        snap_ready = 1'b0;
    endtask

    task automatic test_stale();
`ifdef LATCH_BANK_STALE_EN
        enable[3] = 1'b1; mode[3] = 1'b0;
        tick();
        enable[3] = 1'b0;
        for (int k = 1; k <= LIM; k++) begin
            tick();
            n_cmp++;
            if (stale[3] !== (k == LIM)) begin
                n_err++; $display("FAIL stale3 idle=%0d got=%b want=%b", k, stale[3], (k == LIM));
            end
        end
        enable[3] = 1'b1;
        tick();
        n_cmp++; if (stale[3] !== 1'b0) begin n_err++; $display("FAIL stale3_clear got=%b want=0", stale[3]); end
        enable[3] = 1'b0;
`else
        for (int k = 0; k < 2 * LIM; k++) begin
            tick();
            n_cmp++;
            if (stale !== '0) begin n_err++; $display("FAIL stale_off got=%b want=0", stale); end
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            d = $urandom();
            enable = CH'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mode = CH'($urandom());
            snap_req = ($urandom_range(0, 2) == 0);
            snap_ready = ($urandom_range(0, 1) == 0);
            tick();
            n_cmp++;
            if (q !== model_qvec() || snap_valid !== m_full || snap_drop !== m_drop ||
                snap_data !== m_snap || stale !== model_stale()) begin
                n_err++;
                $display("FAIL random cyc=%0d got q=%h v=%b dr=%b sd=%h st=%b want q=%h v=%b dr=%b sd=%h st=%b",
                         k, q, snap_valid, snap_drop, snap_data, stale,
                         model_qvec(), m_full, m_drop, m_snap, model_stale());
            end
        end
        snap_req = 1'b0; snap_ready = 1'b0; enable = '0;
    endtask

    task automatic test_async_reset();
        mode = '0; enable = '1; d = 32'hDEADBEEF; snap_req = 1'b1;
        tick();
        snap_req = 1'b0; enable = '0;
        n_cmp++;
        if (snap_valid !== 1'b1 || q !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL pre_reset got v=%b q=%h want v=1 q=deadbeef", snap_valid, q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== '0 || snap_valid !== 1'b0 || snap_data !== '0 || snap_drop !== 1'b0 || stale !== '0) begin
            n_err++; $display("FAIL async_reset got q=%h v=%b sd=%h dr=%b st=%b want all 0",
                              q, snap_valid, snap_data, snap_drop, stale);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_snapshot();
        test_overrun();
        test_stale();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
